// File: rtl/cd_subcode_pkg.sv
// Shared types and constants for the CD subcode Q-channel path
// (deframer and formatter).
package cd_subcode_pkg;

    localparam int unsigned Q_DATA_FRAMES = 96;
    localparam int unsigned Q_CRC_BITS    = 80;
    localparam logic [15:0] Q_CRC_POLY    = 16'h1021;
    localparam int unsigned Q_CNT_W       = 7;

    typedef logic [11:0][7:0] q_words_t;

    typedef enum logic [1:0] {
        HUNT,
        S1,
        DATA
    } q_deframe_state_t;

    // One MSB-first CRC-16/CCITT step.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? Q_CRC_POLY : 16'h0000);
    endfunction

    // The first received bit sits at sr[95]; byte i is therefore sr[95-8i -: 8].
    function automatic q_words_t q_pack(input logic [Q_DATA_FRAMES-1:0] sr);
        q_words_t q;
        for (int i = 0; i < 12; i++) begin
            q[i] = sr[Q_DATA_FRAMES - 1 - 8 * i -: 8];
        end
        return q;
    endfunction

endpackage

// File: rtl/crc16_ccitt_serial.sv
// Bit-serial CRC-16/CCITT register: one bit per enabled cycle, synchronous clear.
module crc16_ccitt_serial
    import cd_subcode_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = 16'h0000;
        end else if (enable_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/q_subcode_deframer.sv
// Locks to S0/S1 sector sync, collects the 96 Q-channel bits of a sector into
// twelve bytes and reports them with a CRC-16 check result.
module q_subcode_deframer
    import cd_subcode_pkg::*;
#(
    parameter int unsigned Q_BIT = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] subByte,
    input  logic       subValid,
    input  logic       subSync,
    output q_words_t   qWords,
    output logic       qValid,
    output logic       crcOk,
    output logic       syncErr
);

    localparam logic [2:0]         QIdx    = Q_BIT[2:0];
    localparam logic [Q_CNT_W-1:0] CntLast = Q_CNT_W'(Q_DATA_FRAMES - 1);
    localparam logic [Q_CNT_W-1:0] CntCrc  = Q_CNT_W'(Q_CRC_BITS);

    q_deframe_state_t         state_q;
    logic [Q_CNT_W-1:0]       cnt_q;
    logic [Q_DATA_FRAMES-1:0] shift_q;
    q_words_t                 q_words_q;
    logic                     crc_ok_q;
    logic                     q_valid_q;
    logic                     sync_err_q;

    logic                     q_bit;
    logic [Q_DATA_FRAMES-1:0] shift_d;
    logic                     last_beat;
    logic                     crc_clear;
    logic                     crc_enable;
    logic [15:0]              crc_val;
    logic                     crc_match;

    always_comb begin
        q_bit     = subByte[QIdx];
        shift_d   = {shift_q[Q_DATA_FRAMES-2:0], q_bit};
        last_beat = (cnt_q == CntLast);
        // The S1 beat restarts the CRC; a sync on that beat restarts the pair instead.
        crc_clear  = subValid && (state_q == S1) && !subSync;
        crc_enable = subValid && (state_q == DATA) && !subSync && (cnt_q < CntCrc);
        // The disc stores the CRC inverted; the last 16 shifted bits are bytes 10/11.
        crc_match  = (crc_val == ~shift_d[15:0]);
    end

    crc16_ccitt_serial u_crc (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .clear_i  (crc_clear),
        .enable_i (crc_enable),
        .bit_i    (q_bit),
        .crc_o    (crc_val)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            shift_q    <= '0;
            q_words_q  <= '0;
            crc_ok_q   <= 1'b0;
            q_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            q_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
            if (subValid) begin
                unique case (state_q)
                    HUNT: begin
                        if (subSync) begin
                            state_q <= S1;
                        end
                    end
                    S1: begin
                        if (!subSync) begin
                            cnt_q   <= '0;
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (subSync && !last_beat) begin
                            sync_err_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= S1;
                        end else if (last_beat) begin
                            shift_q   <= shift_d;
                            q_words_q <= q_pack(shift_d);
                            crc_ok_q  <= crc_match;
                            q_valid_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= HUNT;
                        end else begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign qWords  = q_words_q;
    assign crcOk   = crc_ok_q;
    assign qValid  = q_valid_q;
    assign syncErr = sync_err_q;

endmodule
